// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the receive framer state encoding.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned LEN_W = 11;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PRE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32 (no final XOR).
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    // Eight serial steps, data LSB first
    always_comb begin
        w_crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            w_crc = (w_crc >> 1) ^ (((w_crc[0] ^ data[i]) == 1'b1) ? CRC32_POLY : 32'h0);
        end
    end

    assign crc_out = w_crc;

endmodule

// File: rtl/eth_rx_frame.sv
// Receive framer: strips preamble/SFD, checks FCS/length/PHY error and hides the FCS.
module eth_rx_frame
    import eth_pkg::*;
#(
    parameter int unsigned MIN_PREAMBLE  = 2,
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic        clk125MHz,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_en,
    input  logic        rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_good,
    output logic        out_bad,
    output logic [10:0] frame_len,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] drop_cnt
);

    rx_state_e        r_state;
    logic             r_rx_en;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [31:0]      r_crc;
    logic [LEN_W-1:0] r_len;
    logic             r_err;
    logic [3:0][7:0]  r_dly;
    logic             r_sof_pend;

    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_sof;
    logic             r_out_eof;
    logic             r_out_good;
    logic             r_out_bad;
    logic [LEN_W-1:0] r_frame_len;
    logic [CNT_W-1:0] r_crc_err_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [31:0]      w_crc_next;
    logic             w_rx_start;
    logic             w_crc_ok;
    logic             w_len_ok;

    eth_crc32_d8 u_crc (
        .crc_in  (r_crc),
        .data    (rx_data),
        .crc_out (w_crc_next)
    );

    assign w_rx_start = rx_en && !r_rx_en;
    assign w_crc_ok   = (r_crc == CRC32_RESIDUE);
    assign w_len_ok   = (r_len >= LEN_W'(MIN_FRAME_LEN)) && (r_len <= LEN_W'(MAX_FRAME_LEN));

    // Framer FSM with registered payload stream and end-of-frame verdict
    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rx_en       <= 1'b1;
            r_pre_cnt     <= '0;
            r_crc         <= '0;
            r_len         <= '0;
            r_err         <= 1'b0;
            r_dly         <= '0;
            r_sof_pend    <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_sof     <= 1'b0;
            r_out_eof     <= 1'b0;
            r_out_good    <= 1'b0;
            r_out_bad     <= 1'b0;
            r_frame_len   <= '0;
            r_crc_err_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_rx_en     <= rx_en;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_good  <= 1'b0;
            r_out_bad   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_en) begin
                        if (w_rx_start && (rx_data == PREAMBLE_BYTE)) begin
                            r_state   <= ST_PREAMBLE;
                            r_pre_cnt <= PRE_W'(1);
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!rx_en) begin
                        r_state <= ST_IDLE;
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end else if (rx_data == PREAMBLE_BYTE) begin
                        if (r_pre_cnt != '1) r_pre_cnt <= r_pre_cnt + PRE_W'(1);
                    end else if ((rx_data == SFD_BYTE) && (r_pre_cnt >= PRE_W'(MIN_PREAMBLE))) begin
                        r_state    <= ST_PAYLOAD;
                        r_crc      <= CRC32_INIT;
                        r_len      <= '0;
                        r_err      <= 1'b0;
                        r_sof_pend <= 1'b1;
                    end else begin
                        r_state <= ST_DROP;
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_en) begin
                        r_crc <= w_crc_next;
                        r_dly <= {r_dly[2:0], rx_data};
                        if (r_len != '1) r_len <= r_len + LEN_W'(1);
                        if (rx_er) r_err <= 1'b1;
                        // Four bytes already held: the oldest cannot be FCS, release it
                        if (r_len >= LEN_W'(4)) begin
                            r_out_data  <= r_dly[3];
                            r_out_valid <= 1'b1;
                            r_out_sof   <= r_sof_pend;
                            r_sof_pend  <= 1'b0;
                        end
                    end else begin
                        r_state     <= ST_IDLE;
                        r_sof_pend  <= 1'b0;
                        r_out_eof   <= 1'b1;
                        r_frame_len <= r_len;
                        if (w_crc_ok && !r_err && w_len_ok) begin
                            r_out_good <= 1'b1;
                        end else begin
                            r_out_bad <= 1'b1;
                        end
                        if (!w_crc_ok && (r_crc_err_cnt != '1)) begin
                            r_crc_err_cnt <= r_crc_err_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (!rx_en) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_sof     = r_out_sof;
    assign out_eof     = r_out_eof;
    assign out_good    = r_out_good;
    assign out_bad     = r_out_bad;
    assign frame_len   = r_frame_len;
    assign crc_err_cnt = r_crc_err_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_frame.sv
// Bench for eth_rx_frame: frame table, reset-mid-frame sequence and random frames vs a model.
module tb_eth_rx_frame;

    typedef logic [7:0] byte_q [$];

    typedef struct {
        bit good;
        bit bad;
        int len;
        int cyc;
    } eof_t;

    typedef struct {
        int         npre;
        logic [7:0] sfd;
        int         plen;
        int         flip;
        int         er;
        int         nout;
        bit         eof;
        bit         good;
        int         len;
        int         crc_inc;
        int         drop_inc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_en;
    logic        rx_er;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        out_good;
    logic        out_bad;
    logic [10:0] frame_len;
    logic [15:0] crc_err_cnt;
    logic [15:0] drop_cnt;

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     viol     = 0;
    int     exp_crc  = 0;
    int     exp_drop = 0;
    byte_q  q_out;
    int     q_out_cyc [$];
    int     q_sof_cyc [$];
    eof_t   q_eof [$];
    vec_t   vecs [15];

    eth_rx_frame dut (
        .clk125MHz   (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_en       (rx_en),
        .rx_er       (rx_er),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_good    (out_good),
        .out_bad     (out_bad),
        .frame_len   (frame_len),
        .crc_err_cnt (crc_err_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        eof_t e;
        if (out_valid) begin
            q_out.push_back(out_data);
            q_out_cyc.push_back(cyc);
        end
        if (out_sof) q_sof_cyc.push_back(cyc);
        if (out_sof && !out_valid) viol++;
        if ((out_good && out_bad) || ((out_good || out_bad) != out_eof)) viol++;
        if (out_eof) begin
            e.good = out_good;
            e.bad  = out_bad;
            e.len  = int'(frame_len);
            e.cyc  = cyc;
            q_eof.push_back(e);
        end
    end

    initial begin
        #(8 * 90000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // CRC register value after the given bytes, starting from all ones, no final XOR
    function automatic logic [31:0] crc_raw(input byte_q b, input int start, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, b[start + i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic byte_q build(input int npre, input logic [7:0] sfd, input byte_q pay,
                                    input bit fcs_ok, input int flip);
        byte_q       fb;
        logic [31:0] fcs;
        for (int i = 0; i < npre; i++) fb.push_back(8'h55);
        fb.push_back(sfd);
        foreach (pay[i]) fb.push_back(pay[i]);
        fcs = fcs_ok ? ~crc_raw(pay, 0, pay.size()) : 32'($urandom);
        for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
        if (flip >= 0) fb[npre + 1 + flip] ^= 8'h01;
        return fb;
    endfunction

    // Frame-level expectation: SFD search, FCS comparison, length window, error flag
    task automatic model(input byte_q fb, input int er_pos, output bit parsed, output int start,
                         output bit drop_inc, output bit good, output int len, output bit crc_bad);
        int          n = 0;
        int          l;
        bit          crc_ok;
        logic [31:0] rx_fcs;
        parsed = 0; start = 0; drop_inc = 0; good = 0; len = 0; crc_bad = 0;
        while (n < fb.size() && fb[n] == 8'h55) n++;
        if (n == 0) return;
        if (n < fb.size() && fb[n] == 8'hD5 && n >= 2) begin
            parsed = 1;
            start  = n + 1;
            l      = fb.size() - start;
            len    = (l > 2047) ? 2047 : l;
            if (l >= 4) begin
                rx_fcs = {fb[fb.size()-1], fb[fb.size()-2], fb[fb.size()-3], fb[fb.size()-4]};
                crc_ok = (~crc_raw(fb, start, l - 4)) == rx_fcs;
            end else begin
                crc_ok = crc_raw(fb, start, l) == 32'hDEBB20E3;
            end
            crc_bad = !crc_ok;
            good    = crc_ok && !(er_pos >= start) && l >= 64 && l <= 1518;
        end else begin
            drop_inc = 1;
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] d, input logic er);
        @(negedge clk);
        rx_en   = en;
        rx_data = d;
        rx_er   = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic send(input byte_q fb, input int er_pos, input int sfd_pos, output int sfd_edge);
        sfd_edge = -1;
        for (int i = 0; i < fb.size(); i++) begin
            drive(1'b1, fb[i], 1'(i == er_pos));
            if (i == sfd_pos) sfd_edge = cyc + 1;
        end
        idle(8);
    endtask

    task automatic check_frame(input string nm, input byte_q exp_b, input bit exp_eof,
                               input bit exp_good, input int exp_len, input int sfd_edge);
        int mism = 0;
        chk({nm, " out_count"}, q_out.size(), exp_b.size());
        for (int i = 0; i < q_out.size() && i < exp_b.size(); i++) if (q_out[i] !== exp_b[i]) mism++;
        chk({nm, " out_data_mismatches"}, mism, 0);
        chk({nm, " sof_count"}, q_sof_cyc.size(), (exp_b.size() > 0) ? 1 : 0);
        if (exp_b.size() > 0 && q_out.size() > 0 && q_sof_cyc.size() > 0) begin
            chk({nm, " sof_on_first"}, q_sof_cyc[0], q_out_cyc[0]);
            chk({nm, " first_latency"}, q_out_cyc[0] - sfd_edge, 5);
        end
        chk({nm, " eof_count"}, q_eof.size(), exp_eof ? 1 : 0);
        if (exp_eof && q_eof.size() > 0) begin
            chk({nm, " good"}, int'(q_eof[0].good), int'(exp_good));
            chk({nm, " bad"}, int'(q_eof[0].bad), int'(!exp_good));
            chk({nm, " frame_len"}, q_eof[0].len, exp_len);
            if (q_out.size() > 0) chk({nm, " eof_after_last"}, q_eof[0].cyc - q_out_cyc[$], 1);
        end
        chk({nm, " crc_err_cnt"}, int'(crc_err_cnt), exp_crc);
        chk({nm, " drop_cnt"}, int'(drop_cnt), exp_drop);
        q_out.delete();
        q_out_cyc.delete();
        q_sof_cyc.delete();
        q_eof.delete();
    endtask

    initial begin
        byte_q pat60, pay, fb, eb, empty_q;
        int    sfd_edge, er_pos, start, len, plen, npre, flip;
        bit    parsed, drop_inc, good, crc_bad;
        logic [7:0] sfd;

        //          npre sfd    plen  flip er   nout eof good len  crc drop
        vecs[0]  = '{7,  8'hD5, 60,   -1,  -1,  60,  1,  1,   64,  0,  0};
        vecs[1]  = '{7,  8'hD5, 60,   10,  -1,  60,  1,  0,   64,  1,  0};
        vecs[2]  = '{7,  8'hD5, 60,   -1,  30,  60,  1,  0,   64,  0,  0};
        vecs[3]  = '{1,  8'hD5, 60,   -1,  -1,  0,   0,  0,   0,   0,  1};
        vecs[4]  = '{7,  8'hD5, 60,   -1,  -1,  60,  1,  1,   64,  0,  0};
        vecs[5]  = '{7,  8'hD5, 16,   -1,  -1,  16,  1,  0,   20,  0,  0};
        vecs[6]  = '{7,  8'hD5, 1518, -1,  -1,  1518,1,  0,   1522,0,  0};
        vecs[7]  = '{7,  8'hD5, 1514, -1,  -1,  1514,1,  1,   1518,0,  0};
        vecs[8]  = '{7,  8'hD5, 59,   -1,  -1,  59,  1,  0,   63,  0,  0};
        vecs[9]  = '{2,  8'hD5, 60,   -1,  -1,  60,  1,  1,   64,  0,  0};
        vecs[10] = '{7,  8'hD5, 0,    -1,  -1,  0,   1,  0,   4,   0,  0};
        vecs[11] = '{3,  8'hD4, 20,   -1,  -1,  0,   0,  0,   0,   0,  1};
        vecs[12] = '{0,  8'hD5, 20,   -1,  -1,  0,   0,  0,   0,   0,  0};
        vecs[13] = '{20, 8'hD5, 60,   -1,  -1,  60,  1,  1,   64,  0,  0};
        vecs[14] = '{7,  8'hD5, 1,    -1,  -1,  1,   1,  0,   5,   0,  0};

        rst = 1'b1; rx_en = 1'b0; rx_data = 8'h00; rx_er = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_eof", int'(out_eof), 0);
        chk("reset out_good_bad", int'({out_good, out_bad, out_sof}), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset frame_len", int'(frame_len), 0);
        chk("reset counters", int'({crc_err_cnt, drop_cnt}), 0);
        rst = 1'b0;
        idle(4);

        // Table of whole frames with hand-derived outcomes
        for (int v = 0; v < 15; v++) begin
            pay.delete();
            for (int i = 0; i < vecs[v].plen; i++) pay.push_back(8'(i));
            fb = build(vecs[v].npre, vecs[v].sfd, pay, 1'b1, vecs[v].flip);
            er_pos = (vecs[v].er >= 0) ? vecs[v].npre + 1 + vecs[v].er : -1;
            send(fb, er_pos, vecs[v].npre, sfd_edge);
            eb.delete();
            for (int i = 0; i < vecs[v].nout; i++) eb.push_back(fb[vecs[v].npre + 1 + i]);
            exp_crc  += vecs[v].crc_inc;
            exp_drop += vecs[v].drop_inc;
            check_frame($sformatf("vec%0d", v), eb, vecs[v].eof, vecs[v].good, vecs[v].len, sfd_edge);
        end

        // Reset at payload byte 25, released while rx_en is still high
        for (int i = 0; i < 60; i++) pat60.push_back(8'(i));
        fb = build(7, 8'hD5, pat60, 1'b1, -1);
        for (int i = 0; i < fb.size(); i++) begin
            drive(1'b1, fb[i], 1'b0);
            if (i == 34) begin
                chk("mid_rst out_valid", int'(out_valid), 0);
                chk("mid_rst out_data", int'(out_data), 0);
                chk("mid_rst counters", int'({crc_err_cnt, drop_cnt}), 0);
                q_out.delete();
                q_out_cyc.delete();
                q_sof_cyc.delete();
                q_eof.delete();
                exp_crc  = 0;
                exp_drop = 0;
            end
            if (i == 33) rst = 1'b1;
            if (i == 35) rst = 1'b0;
        end
        idle(8);
        check_frame("mid_rst_tail", empty_q, 1'b0, 1'b0, 0, 0);
        send(fb, -1, 7, sfd_edge);
        eb.delete();
        for (int i = 0; i < 60; i++) eb.push_back(fb[8 + i]);
        check_frame("after_rst", eb, 1'b1, 1'b1, 64, sfd_edge);

        // Random frames against the frame-level model
        for (int f = 0; f < 30; f++) begin
            npre = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 9));
            sfd  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hD5;
            plen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1490, 1530)) : int'($urandom_range(0, 100));
            pay.delete();
            for (int i = 0; i < plen; i++) pay.push_back(8'($urandom));
            flip = (plen > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, plen - 1)) : -1;
            fb = build(npre, sfd, pay, $urandom_range(0, 99) < 85, flip);
            er_pos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, fb.size() - 1)) : -1;
            model(fb, er_pos, parsed, start, drop_inc, good, len, crc_bad);
            send(fb, er_pos, parsed ? start - 1 : -1, sfd_edge);
            eb.delete();
            if (parsed) for (int i = 0; i < int'(fb.size()) - start - 4; i++) eb.push_back(fb[start + i]);
            exp_crc  += int'(crc_bad);
            exp_drop += int'(drop_inc);
            check_frame($sformatf("rand%0d", f), eb, parsed, good, len, sfd_edge);
        end

        chk("verdict_invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame.md
Name: eth_rx_frame

Overview:
Receive framer downstream of the RGMII receive stage, in the clk125MHz domain. It consumes the byte stream (data, enable, error) that the RGMII receiver hands over through its clock-crossing FIFO. It strips preamble/SFD, checks CRC-32, length and PHY error, and removes the 4-byte FCS. It then presents the payload bytes to the MAC/UDP parser with a start marker and an end-of-frame good/bad verdict.

Parameters:
MIN_PREAMBLE, 2, minimum count of 0x55 bytes before 0xD5 for the SFD to be accepted
MIN_FRAME_LEN, 64, minimum bytes after SFD (including FCS) for a good frame
MAX_FRAME_LEN, 1518, maximum bytes after SFD (including FCS) for a good frame

Ports:
clk125MHz  in  1  system clock; all logic in this domain
rst  in  1  synchronous reset, active-high
rx_data  in  8  byte from the receive FIFO (raw_data_f)
rx_en  in  1  byte valid / frame active (data_enable_f)
rx_er  in  1  PHY receive error flag (data_error)
out_data  out  8  payload byte, FCS excluded
out_valid  out  1  out_data valid this cycle
out_sof  out  1  high with the first out_valid of a frame
out_eof  out  1  one-cycle end-of-frame pulse
out_good  out  1  with out_eof: frame passed all checks
out_bad  out  1  with out_eof: frame failed a check
frame_len  out  11  bytes after SFD incl. FCS; valid with out_eof; saturates at 2047
crc_err_cnt  out  16  saturating count of frames ending with a CRC mismatch
drop_cnt  out  16  saturating count of frames dropped for bad preamble/SFD

Behaviour:
- Interface: one clock (clk125MHz); rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE. The internal registered copy of rx_en resets to 1, so a frame already in progress at reset release is dropped, not parsed.
- States: IDLE, PREAMBLE, PAYLOAD, DROP.
- IDLE: frame start is rx_en=1 with the previous-cycle rx_en=0.
  - Start with byte 0x55 -> PREAMBLE, pre_cnt=1.
  - Start with any other byte, or rx_en=1 without a rising edge -> DROP.
- PREAMBLE: rx_en=0 -> IDLE, drop_cnt+1.
  - 0x55 -> pre_cnt+1, saturating at 15.
  - 0xD5 with pre_cnt>=MIN_PREAMBLE -> PAYLOAD; CRC reg=0xFFFFFFFF, len=0, err=0.
  - Any other byte -> DROP, drop_cnt+1.
- PAYLOAD, rx_en=1:
  - The byte updates the CRC (reflected poly 0xEDB88320, byte per cycle, no final XOR).
  - len+1, saturating at 2047.
  - The byte shifts into a 4-deep delay line.
  - rx_er=1 sets the sticky flag err.
- Output timing: once the delay line holds 4 bytes, each new byte pushes out the oldest. The pushed-out byte appears on out_data/out_valid one cycle later (registered). Byte k after SFD, received at cycle T+k, is output at cycle T+k+5. out_sof is high on the first such output.
- PAYLOAD, rx_en=0 at cycle E: the frame ends and the delay-line contents (the FCS) are discarded.
  - At E+1: out_eof=1, frame_len=len.
  - out_good=1 iff CRC reg==0xDEBB20E3, err=0, and MIN_FRAME_LEN<=len<=MAX_FRAME_LEN.
  - Otherwise out_bad=1. crc_err_cnt+1 if the CRC mismatched.
  - State -> IDLE.
- Edge cases:
  - The last payload byte comes out at cycle E, one cycle before out_eof.
  - A frame with len<=4 produces no out_valid but still produces out_eof/out_bad.
  - out_good and out_bad are never both high, and never high without out_eof.
- DROP: no output. Stay until rx_en=0, then -> IDLE.
- rx_er outside PAYLOAD is ignored. The inter-frame status nibbles carried on rx_data when rx_en=0 are ignored.
- Counters saturate at 0xFFFF and clear only on rst.
- Reset mid-frame: outputs clear next cycle and no out_eof is issued for the interrupted frame.

Decomposition:
- Shared package eth_pkg: PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, CRC32_POLY 32'hEDB88320, CRC32_INIT 32'hFFFFFFFF, CRC32_RESIDUE 32'hDEBB20E3, and the rx framer state encoding.
- Sub-module eth_crc32_d8: combinational next-CRC from crc_in[31:0] and data[7:0]. It is reused by the transmit path.

Test Plan:
- 7×0x55, 0xD5, 60 bytes 0x00..0x3B, then the correct FCS (LSB first) -> 60 out_valid bytes 0x00..0x3B, first with out_sof. One cycle after the last: out_eof=1, out_good=1, frame_len=64.
- Same frame with payload byte 10 XOR 0x01 -> out_eof with out_bad=1, crc_err_cnt=1, 60 bytes still emitted.
- Valid frame with rx_er=1 for one cycle at payload byte 30 -> out_bad=1, crc_err_cnt unchanged.
- 0x55, 0xD5 (pre_cnt=1 < 2), then payload -> no output, drop_cnt=1. The next valid frame is received good.
- Valid 20-byte frame (16 payload + correct FCS) -> 16 bytes out, out_bad=1, frame_len=20. A 1522-byte frame with correct FCS -> out_bad=1, frame_len=1522.
- rst asserted at payload byte 25 and released with rx_en still 1 -> no out_eof for that frame. Block idles in DROP until rx_en=0, then receives the next frame good.
